wb_ram_burst: RTL
=================

// Module: wb_ram_burst
// PURPOSE
//  Parametrised Wishbone B4 registered-feedback RAM slave; next generation of the 1 KiB single-word RAM.
//  Adds configurable width/depth, byte-lane writes (sel_i), incrementing/wrapping bursts (cti_i/bte_i) at one beat per clock,
//  and a post-reset memory clear engine. Sits on the system bus behind the address decoder as main/scratch RAM.
// PARAMETERS
//  DAT_WIDTH      64    data bus width in bits; multiple of 8, power of two
//  ADR_WIDTH      32    byte-address width
//  WORDS          1024  depth in DAT_WIDTH words; power of two
//  CLEAR_ON_RESET 1     1: zero every word after reset before accepting cycles; 0: contents undefined after reset
// PORTS
//  clk_i        in   1             system clock
//  rst_i        in   1             asynchronous reset, active-high
//  ram_cyc_i    in   1             bus cycle in progress
//  ram_stb_i    in   1             strobe: beat valid
//  ram_we_i     in   1             1 write, 0 read
//  ram_adr_i    in   ADR_WIDTH     byte address; low log2(DAT_WIDTH/8) bits ignored
//  ram_sel_i    in   DAT_WIDTH/8   byte-lane enables
//  ram_dat_i    in   DAT_WIDTH     write data
//  ram_cti_i    in   3             000 classic, 010 incrementing burst, 111 end-of-burst
//  ram_bte_i    in   2             00 linear, 01 wrap-4, 10 wrap-8, 11 wrap-16
//  ram_dat_o    out  DAT_WIDTH     read data, valid while ram_ack_o high
//  ram_ack_o    out  1             beat complete
//  ram_err_o    out  1             beat failed (address out of range)
//  ram_busy_o   out  1             clear engine running; cycles stalled
// BEHAVIOUR
//  Reset (async): state<=CLEAR (or IDLE if CLEAR_ON_RESET=0); ack_o=0, err_o=0, dat_o=0, busy_o=CLEAR_ON_RESET; clear counter=0.
//  Reset never touches the memory array; clearing is synchronous via the clear engine only.
//  Word index = adr_i >> log2(DAT_WIDTH/8). Index >= WORDS -> out of range.
//  Outputs gated: ack_o/err_o forced 0 whenever (cyc_i & stb_i)=0.
//  CLEAR: write 0 to word[cnt], cnt+1 per clock; after word WORDS-1 -> IDLE, busy_o<=0 (WORDS clocks total).
//    Requests during CLEAR are held (no ack/err) and serviced from IDLE afterwards.
//  IDLE: on cyc&stb sample beat. Out of range -> err next clock, no write, dat_o unchanged, -> WAIT_END.
//    In range write: bytes with sel_i[b]=1 updated; others kept. Read: dat_o<=word (all lanes, sel ignored).
//    ack next clock (1-clock latency). cti=010 -> BURST, else -> WAIT_END.
//  BURST: ack stays high each clock stb is held; per acked beat, next address = current + DAT_WIDTH/8,
//    wrapped within 4/8/16-word aligned block per bte (linear: no wrap). Reads prefetch predicted word so
//    data for the following beat is in dat_o at the next clock. Writes use master's adr_i/dat_i of the acked beat.
//    stb low while cyc high: insert wait; ack low; resume with predicted address on stb return.
//    cti=111 beat acked -> WAIT_END. Linear burst crossing WORDS-1 -> err on the offending beat, burst ends.
//    Master address differing from prediction: that beat is not acked; restart as classic from IDLE rules.
//  WAIT_END: ack/err held while stb high (classic); stb or cyc low -> ack<=0, err<=0, -> IDLE.
//  cyc_i low in any non-CLEAR state aborts immediately -> IDLE; beats already acked are committed.
//  Write and read of same word in consecutive beats: read returns newly written bytes (write-first).
//  Reset mid-burst: outputs drop asynchronously; any unacked write is lost.
// STRUCTURE
//  Shared package/header (wishbone.v): CTI_CLASSIC/CTI_INCR/CTI_EOB, BTE_* codes, slave port macro with sel/cti/bte.
//  State encodings CLEAR/IDLE/BURST/WAIT_END as localparams here.
//  Sub-module ram_byte_array: single-port synchronous RAM, per-byte write enable, read-first-with-bypass; infers BRAM.
//  Burst address predictor (wrap mask by bte) is a function in utils.v.
// TESTING
//  Reset, CLEAR_ON_RESET=1 WORDS=16: busy_o high 16 clocks; read adr 0x78 afterwards -> dat 0, ack 1 clock after stb.
//  Classic write 0x1122334455667788 @0x10 sel=0xFF, then write 0xAAAA... sel=0x0F, read -> 0x11223344AAAAAAAA.
//  Incr linear burst read 4 beats from 0x00 after writing words 0..3 = 0,1,2,3 -> ack 4 consecutive clocks, data 0,1,2,3.
//  Wrap-4 burst from 0x10 (word 2) -> data words 2,3,0,1; wait state mid-burst (stb low 2 clocks) -> no ack, order kept.
//  Read adr WORDS*8 (out of range) -> err 1 clock after stb, ack 0; memory unchanged; err drops with stb.
//  Assert rst_i mid write burst -> ack/err 0 same cycle; after clear, all words read 0.

Source files
------------

// File: rtl/wb_ram_burst_pkg.sv
// Shared Wishbone B4 codes, FSM state type and burst address helper for wb_ram_burst.
package wb_ram_burst_pkg;

    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_EOB    = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        S_CLEAR    = 2'd0,
        S_IDLE     = 2'd1,
        S_BURST    = 2'd2,
        S_WAIT_END = 2'd3
    } state_t;

    // Next word index of a burst; wrapping bursts stay inside their aligned 4/8/16-word block.
    function automatic logic [63:0] burst_next(input logic [63:0] idx, input logic [1:0] bte);
        logic [63:0] inc;
        logic [63:0] mask;
        inc = idx + 64'd1;
        case (bte)
            BTE_WRAP4:  mask = 64'd3;
            BTE_WRAP8:  mask = 64'd7;
            BTE_WRAP16: mask = 64'd15;
            default:    mask = 64'd0;
        endcase
        if (bte == BTE_LINEAR) begin
            return inc;
        end
        return (idx & ~mask) | (inc & mask);
    endfunction

endpackage

// File: rtl/wb_ram_burst_byte_array.sv
// Single-port synchronous RAM with per-byte write enables; the read port returns freshly written bytes.
module wb_ram_burst_byte_array #(
    parameter int DAT_WIDTH = 64,
    parameter int ADR_BITS  = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   i_en,
    input  logic [DAT_WIDTH/8-1:0] i_we,
    input  logic [ADR_BITS-1:0]    i_addr,
    input  logic [DAT_WIDTH-1:0]   i_wdata,
    output logic [DAT_WIDTH-1:0]   o_rdata
);

    localparam int NB    = DAT_WIDTH / 8;
    localparam int DEPTH = 1 << ADR_BITS;

    logic [DAT_WIDTH-1:0] r_mem [DEPTH];
    logic [DAT_WIDTH-1:0] r_rdata;
    logic [DAT_WIDTH-1:0] w_merged;

    always_comb begin
        w_merged = r_mem[i_addr];
        for (int b = 0; b < NB; b++) begin
            if (i_we[b]) begin
                w_merged[b*8 +: 8] = i_wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (i_en) begin
            for (int b = 0; b < NB; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Only the output register is reset; the array contents survive reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rdata <= '0;
        end else if (i_en) begin
            r_rdata <= w_merged;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wb_ram_burst.sv
// Wishbone B4 registered-feedback RAM slave with byte lanes, incrementing/wrapping bursts and a post-reset clear engine.
module wb_ram_burst
    import wb_ram_burst_pkg::*;
#(
    parameter int DAT_WIDTH      = 64,
    parameter int ADR_WIDTH      = 32,
    parameter int WORDS          = 1024,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ram_cyc_i,
    input  logic                   ram_stb_i,
    input  logic                   ram_we_i,
    input  logic [ADR_WIDTH-1:0]   ram_adr_i,
    input  logic [DAT_WIDTH/8-1:0] ram_sel_i,
    input  logic [DAT_WIDTH-1:0]   ram_dat_i,
    input  logic [2:0]             ram_cti_i,
    input  logic [1:0]             ram_bte_i,
    output logic [DAT_WIDTH-1:0]   ram_dat_o,
    output logic                   ram_ack_o,
    output logic                   ram_err_o,
    output logic                   ram_busy_o,
    output state_t                 dbg_state_o
);

    localparam int NB     = DAT_WIDTH / 8;
    localparam int OFF_W  = $clog2(NB);
    localparam int IDX_W  = ADR_WIDTH - OFF_W;
    localparam int MEM_AW = $clog2(WORDS);
    localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_IDLE;

    state_t             r_state, w_nxt_state;
    logic               r_ack, w_nxt_ack;
    logic               r_err, w_nxt_err;
    logic               r_busy, w_nxt_busy;
    logic [MEM_AW-1:0]  r_clr_cnt, w_nxt_clr;
    logic [IDX_W-1:0]   r_cur_idx, w_nxt_cur;
    logic [1:0]         r_bte, w_nxt_bte;

    logic               w_req;
    logic [IDX_W-1:0]   w_bus_idx;
    logic               w_bus_oor;
    logic               w_match;
    logic [63:0]        w_next_ext;
    logic               w_next_oor;
    logic               w_unused_adr;

    logic               w_mem_en;
    logic [NB-1:0]      w_mem_we;
    logic [MEM_AW-1:0]  w_mem_addr;
    logic [DAT_WIDTH-1:0] w_mem_wdata;

    assign w_req        = ram_cyc_i & ram_stb_i;
    assign w_bus_idx    = ram_adr_i[ADR_WIDTH-1:OFF_W];
    assign w_unused_adr = ^ram_adr_i[OFF_W-1:0];
    assign w_bus_oor    = {1'b0, w_bus_idx} >= (IDX_W+1)'(WORDS);
    assign w_match      = (w_bus_idx == r_cur_idx);
    assign w_next_ext   = burst_next(64'(r_cur_idx), r_bte);
    assign w_next_oor   = w_next_ext >= 64'(WORDS);

    // r_cur_idx is the word whose data sits in ram_dat_o; a burst beat is acked only if the master asks for it.
    assign ram_ack_o   = r_ack & w_req & ((r_state != S_BURST) | w_match);
    assign ram_err_o   = r_err & w_req;
    assign ram_busy_o  = r_busy;
    assign dbg_state_o = r_state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= RESET_STATE;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_busy    <= (CLEAR_ON_RESET != 0);
            r_clr_cnt <= '0;
            r_cur_idx <= '0;
            r_bte     <= BTE_LINEAR;
        end else begin
            r_state   <= w_nxt_state;
            r_ack     <= w_nxt_ack;
            r_err     <= w_nxt_err;
            r_busy    <= w_nxt_busy;
            r_clr_cnt <= w_nxt_clr;
            r_cur_idx <= w_nxt_cur;
            r_bte     <= w_nxt_bte;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_ack   = r_ack;
        w_nxt_err   = r_err;
        w_nxt_busy  = r_busy;
        w_nxt_clr   = r_clr_cnt;
        w_nxt_cur   = r_cur_idx;
        w_nxt_bte   = r_bte;
        w_mem_en    = 1'b0;
        w_mem_we    = '0;
        w_mem_addr  = w_bus_idx[MEM_AW-1:0];
        w_mem_wdata = ram_dat_i;
        case (r_state)
            S_CLEAR: begin
                w_mem_en    = 1'b1;
                w_mem_we    = '1;
                w_mem_addr  = r_clr_cnt;
                w_mem_wdata = '0;
                w_nxt_clr   = r_clr_cnt + MEM_AW'(1);
                if (r_clr_cnt == MEM_AW'(WORDS - 1)) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_busy  = 1'b0;
                end
            end
            S_IDLE: begin
                if (w_req) begin
                    if (w_bus_oor) begin
                        w_nxt_err   = 1'b1;
                        w_nxt_ack   = 1'b0;
                        w_nxt_state = S_WAIT_END;
                    end else begin
                        w_mem_en    = 1'b1;
                        w_mem_we    = ram_we_i ? ram_sel_i : '0;
                        w_nxt_ack   = 1'b1;
                        w_nxt_err   = 1'b0;
                        w_nxt_cur   = w_bus_idx;
                        w_nxt_bte   = ram_bte_i;
                        w_nxt_state = (ram_cti_i == CTI_INCR) ? S_BURST : S_WAIT_END;
                    end
                end
            end
            S_BURST: begin
                if (!ram_cyc_i) begin
                    w_nxt_ack   = 1'b0;
                    w_nxt_err   = 1'b0;
                    w_nxt_state = S_IDLE;
                end else if (ram_stb_i) begin
                    if (!w_match) begin
                        w_nxt_ack   = 1'b0;
                        w_nxt_state = S_IDLE;
                    end else begin
                        if (ram_we_i) begin
                            w_mem_en = 1'b1;
                            w_mem_we = ram_sel_i;
                        end
                        if (ram_cti_i == CTI_EOB) begin
                            w_nxt_ack   = 1'b0;
                            w_nxt_state = S_WAIT_END;
                        end else if (w_next_oor) begin
                            w_nxt_ack   = 1'b0;
                            w_nxt_err   = 1'b1;
                            w_nxt_state = S_WAIT_END;
                        end else begin
                            w_nxt_cur = w_next_ext[IDX_W-1:0];
                            // Prefetch the predicted word so the next beat's data is ready one clock later.
                            if (!ram_we_i) begin
                                w_mem_en   = 1'b1;
                                w_mem_addr = w_next_ext[MEM_AW-1:0];
                            end
                        end
                    end
                end
            end
            S_WAIT_END: begin
                if (!w_req) begin
                    w_nxt_ack   = 1'b0;
                    w_nxt_err   = 1'b0;
                    w_nxt_state = S_IDLE;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    wb_ram_burst_byte_array #(
        .DAT_WIDTH (DAT_WIDTH),
        .ADR_BITS  (MEM_AW)
    ) u_mem (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_en    (w_mem_en),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (ram_dat_o)
    );

endmodule
